// File: rtl/riscv_dmem_arbiter.sv
// riscv_dmem_arbiter: shares the dmem port between the MEM stage (M0) and an external master (M1).
// Define DMEM_ARB_STARVE_EN to let M1 win after STARVE_MAX consecutive losses to M0.
module riscv_dmem_arbiter #(
  parameter int XLEN       = 32,
  parameter int BSEL_W     = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_core_req,
  input  logic              i_core_wen,
  input  logic [XLEN-1:0]   i_core_addr,
  input  logic [XLEN-1:0]   i_core_wdata,
  input  logic [BSEL_W-1:0] i_core_bsel,
  output logic              o_core_gnt,
  output logic              o_core_stall,
  output logic              o_core_rvalid,
  input  logic              i_ext_req,
  input  logic              i_ext_lock,
  input  logic              i_ext_wen,
  input  logic [XLEN-1:0]   i_ext_addr,
  input  logic [XLEN-1:0]   i_ext_wdata,
  input  logic [BSEL_W-1:0] i_ext_bsel,
  output logic              o_ext_gnt,
  output logic              o_ext_rvalid,
  output logic [XLEN-1:0]   o_rdata,
  output logic              o_dmem_wr_en,
  output logic [XLEN-1:0]   o_dmem_addr,
  output logic [XLEN-1:0]   o_dmem_data,
  output logic [BSEL_W-1:0] o_dmem_byte_sel,
  input  logic [XLEN-1:0]   i_dmem_data
);
  typedef enum logic {ST_CORE, ST_EXT_LOCK} state_t;
  state_t state, state_nxt;
  logic core_gnt, ext_gnt, starve_win, rd_core, rd_ext;
`ifdef DMEM_ARB_STARVE_EN
  localparam int SC = $clog2(STARVE_MAX + 1);
  localparam int SW = (SC > 4) ? SC : 4;
  logic [SW-1:0] starve;
  assign starve_win = (starve == SW'(STARVE_MAX)) && i_ext_req;
  // saturating count of consecutive cycles M1 lost to M0
  always_ff @(posedge i_clk)
    if (i_rst || ext_gnt || !i_ext_req) starve <= '0;
    else if (core_gnt && starve != SW'(STARVE_MAX)) starve <= starve + 1'b1;
`else
  assign starve_win = 1'b0;
`endif
  always_comb begin
    core_gnt  = !i_rst && state == ST_CORE && i_core_req && !starve_win;
    ext_gnt   = !i_rst && i_ext_req && !core_gnt;
    state_nxt = state == ST_CORE ? ((ext_gnt && i_ext_lock) ? ST_EXT_LOCK : ST_CORE)
                                 : (i_ext_lock ? ST_EXT_LOCK : ST_CORE);
  end
  always_ff @(posedge i_clk) begin
    state   <= i_rst ? ST_CORE : state_nxt;
    rd_core <= !i_rst && core_gnt && !i_core_wen;
    rd_ext  <= !i_rst && ext_gnt && !i_ext_wen;
  end
  assign o_core_gnt      = core_gnt;
  assign o_ext_gnt       = ext_gnt;
  assign o_core_stall    = i_core_req && !core_gnt;
  // a read in flight is dropped if reset lands on its return cycle
  assign o_core_rvalid   = rd_core && !i_rst;
  assign o_ext_rvalid    = rd_ext && !i_rst;
  assign o_rdata         = (o_core_rvalid || o_ext_rvalid) ? i_dmem_data : '0;
  assign o_dmem_wr_en    = core_gnt ? i_core_wen   : ext_gnt ? i_ext_wen   : 1'b0;
  assign o_dmem_addr     = core_gnt ? i_core_addr  : ext_gnt ? i_ext_addr  : '0;
  assign o_dmem_data     = core_gnt ? i_core_wdata : ext_gnt ? i_ext_wdata : '0;
  assign o_dmem_byte_sel = core_gnt ? i_core_bsel  : ext_gnt ? i_ext_bsel  : '0;
endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// tb_riscv_dmem_arbiter: directed stimulus with a read-return scoreboard for riscv_dmem_arbiter.
module tb_riscv_dmem_arbiter;
`ifdef DMEM_ARB_STARVE_EN
  localparam int SM = 2;
`else
  localparam int SM = 8;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic core_req = 0, core_wen = 0, ext_req = 0, ext_lock = 0, ext_wen = 0;
  logic [31:0] core_addr = 0, core_wdata = 0, ext_addr = 0, ext_wdata = 0;
  logic [3:0] core_bsel = 0, ext_bsel = 0;
  logic core_gnt, core_stall, core_rvalid, ext_gnt, ext_rvalid, dmem_wr_en;
  logic [31:0] rdata, dmem_addr, dmem_data, dmem_rdata = 0;
  logic [3:0] dmem_bsel;
  int checks = 0, errors = 0;
  logic [32:0] exp_q[$];
  riscv_dmem_arbiter #(.XLEN(32), .BSEL_W(4), .STARVE_MAX(SM)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_core_req(core_req), .i_core_wen(core_wen), .i_core_addr(core_addr),
    .i_core_wdata(core_wdata), .i_core_bsel(core_bsel),
    .o_core_gnt(core_gnt), .o_core_stall(core_stall), .o_core_rvalid(core_rvalid),
    .i_ext_req(ext_req), .i_ext_lock(ext_lock), .i_ext_wen(ext_wen), .i_ext_addr(ext_addr),
    .i_ext_wdata(ext_wdata), .i_ext_bsel(ext_bsel),
    .o_ext_gnt(ext_gnt), .o_ext_rvalid(ext_rvalid), .o_rdata(rdata),
    .o_dmem_wr_en(dmem_wr_en), .o_dmem_addr(dmem_addr), .o_dmem_data(dmem_data),
    .o_dmem_byte_sel(dmem_bsel), .i_dmem_data(dmem_rdata)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a == 32'h10 ? 32'hDEADBEEF : a ^ 32'hA5A5_0000;
  endfunction
  // synchronous memory model: one-cycle read latency on the address actually driven
  always @(posedge clk)
    dmem_rdata <= ((core_gnt || ext_gnt) && !dmem_wr_en) ? data_of(dmem_addr) : 32'h0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic is_ext, input logic [31:0] a);
    exp_q.push_back({is_ext, data_of(a)});
  endtask
  // monitor: every rvalid must match the oldest expected read return
  always @(negedge clk) begin
    if (core_rvalid && ext_rvalid) chk("both_rvalid", 32'd1, 32'd0);
    else if (core_rvalid || ext_rvalid) begin
      if (exp_q.size() == 0) chk("unexpected_rvalid", {31'd0, ext_rvalid}, 32'hFFFF_FFFF);
      else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("rvalid_owner_ext", {31'd0, ext_rvalid}, {31'd0, e[32]});
        chk("rdata", rdata, e[31:0]);
      end
    end
  end
  initial begin
    core_req = 1; ext_req = 1; ext_wen = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_core_gnt", {31'd0, core_gnt}, 32'd0);
      chk("rst_ext_gnt", {31'd0, ext_gnt}, 32'd0);
      chk("rst_stall", {31'd0, core_stall}, 32'd1);
      chk("rst_wr_en", {31'd0, dmem_wr_en}, 32'd0);
      chk("rst_rvalid", {30'd0, core_rvalid, ext_rvalid}, 32'd0);
      chk("rst_addr", dmem_addr, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      tick();
    end
    rst = 0; core_wen = 0; core_addr = 32'h10; ext_addr = 32'h50;
    push(0, 32'h10);
    @(negedge clk);
    chk("rel_core_gnt", {31'd0, core_gnt}, 32'd1);
    chk("rel_ext_gnt", {31'd0, ext_gnt}, 32'd0);
    chk("rel_addr", dmem_addr, 32'h10);
    tick();
    core_req = 0; ext_req = 0;
    @(negedge clk);
    chk("m0_read_rvalid", {30'd0, core_rvalid, ext_rvalid}, 32'd2);
    chk("m0_read_rdata", rdata, 32'hDEADBEEF);
    tick();
    core_req = 1; core_wen = 1; core_addr = 32'h20; core_wdata = 32'h1111; core_bsel = 4'hF;
    ext_req = 1; ext_wen = 1; ext_addr = 32'h40; ext_wdata = 32'h2222; ext_bsel = 4'h3;
    for (int i = 0; i < 4; i++) begin
      logic s;
`ifdef DMEM_ARB_STARVE_EN
      s = (i == 2);
`else
      s = 1'b0;
`endif
      @(negedge clk);
      chk("wr_core_gnt", {31'd0, core_gnt}, {31'd0, !s});
      chk("wr_ext_gnt", {31'd0, ext_gnt}, {31'd0, s});
      chk("wr_stall", {31'd0, core_stall}, {31'd0, s});
      chk("wr_en", {31'd0, dmem_wr_en}, 32'd1);
      chk("wr_addr", dmem_addr, s ? 32'h40 : 32'h20);
      chk("wr_data", dmem_data, s ? 32'h2222 : 32'h1111);
      chk("wr_bsel", {28'd0, dmem_bsel}, s ? 32'h3 : 32'hF);
      tick();
    end
    core_req = 0; core_wen = 0; core_addr = 32'h30;
    ext_wen = 0; ext_lock = 1;
    for (int i = 0; i < 3; i++) begin
      ext_addr = 32'h100 + 32'(4 * i);
      ext_lock = (i < 2);
      push(1, ext_addr);
      @(negedge clk);
      chk("burst_ext_gnt", {31'd0, ext_gnt}, 32'd1);
      chk("burst_core_gnt", {31'd0, core_gnt}, 32'd0);
      chk("burst_addr", dmem_addr, ext_addr);
      if (i > 0) chk("burst_stall", {31'd0, core_stall}, 32'd1);
      tick();
      core_req = 1;
    end
    ext_req = 0; ext_lock = 0;
    push(0, 32'h30);
    @(negedge clk);
    chk("post_lock_core_gnt", {31'd0, core_gnt}, 32'd1);
    chk("post_lock_stall", {31'd0, core_stall}, 32'd0);
    tick();
    core_addr = 32'h0; push(0, 32'h0);
    @(negedge clk);
    chk("alt0_core_gnt", {31'd0, core_gnt}, 32'd1);
    tick();
    core_req = 0; ext_req = 1; ext_addr = 32'h4; push(1, 32'h4);
    @(negedge clk);
    chk("alt1_ext_gnt", {31'd0, ext_gnt}, 32'd1);
    tick();
    ext_req = 0; core_req = 1; core_addr = 32'h8; push(0, 32'h8);
    @(negedge clk);
    chk("alt2_core_gnt", {31'd0, core_gnt}, 32'd1);
    tick();
    core_req = 0; ext_req = 1; ext_lock = 1; ext_addr = 32'h200;
    @(negedge clk);
    chk("pre_rst_ext_gnt", {31'd0, ext_gnt}, 32'd1);
    tick();
    rst = 1; ext_req = 0;
    @(negedge clk);
    chk("mid_rst_ext_rvalid", {31'd0, ext_rvalid}, 32'd0);
    chk("mid_rst_ext_gnt", {31'd0, ext_gnt}, 32'd0);
    tick();
    rst = 0; core_req = 1; core_addr = 32'h44; ext_req = 1; ext_addr = 32'h204;
    push(0, 32'h44);
    @(negedge clk);
    chk("after_rst_core_gnt", {31'd0, core_gnt}, 32'd1);
    chk("after_rst_ext_gnt", {31'd0, ext_gnt}, 32'd0);
    tick();
    core_req = 0; ext_req = 0; ext_lock = 0;
    repeat (3) tick();
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/riscv_dmem_arbiter.md
Name: riscv_dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters: M0, the pipeline MEM stage, and M1, an external master such as a program loader or debug access.
- Sits between the MEM-stage dmem interface and the dmem.
- Arbitrates every cycle, locks grant for M1 bursts, tracks ownership of the in-flight read, and stalls the core when it loses arbitration.

Parameters:
XLEN, 32, data/address width
BSEL_W, 4, byte-select width (XLEN/8)
STARVE_MAX, 8, max consecutive cycles M1 waits while M0 wins (only with DMEM_ARB_STARVE_EN)

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst  in  1  synchronous reset, active-high
i_core_req  in  1  M0 access request (valid for one cycle per access)
i_core_wen  in  1  M0 write enable (0 = read)
i_core_addr  in  XLEN  M0 byte address
i_core_wdata  in  XLEN  M0 write data
i_core_bsel  in  BSEL_W  M0 byte select
o_core_gnt  out  1  M0 granted this cycle
o_core_stall  out  1  i_core_req & ~o_core_gnt
o_core_rvalid  out  1  M0 read data valid
i_ext_req  in  1  M1 request
i_ext_lock  in  1  M1 holds grant after the current access
i_ext_wen  in  1  M1 write enable
i_ext_addr  in  XLEN  M1 byte address
i_ext_wdata  in  XLEN  M1 write data
i_ext_bsel  in  BSEL_W  M1 byte select
o_ext_gnt  out  1  M1 granted this cycle
o_ext_rvalid  out  1  M1 read data valid
o_rdata  out  XLEN  read data, qualified by the rvalid of the owning master
o_dmem_wr_en  out  1  to dmem
o_dmem_addr  out  XLEN  to dmem
o_dmem_data  out  XLEN  to dmem
o_dmem_byte_sel  out  BSEL_W  to dmem
i_dmem_data  in  XLEN  dmem synchronous read data, 1-cycle latency

Behaviour:
- Reset: one clock, synchronous, active-high; i_rst (polarity and synchronicity fixed).
  - While i_rst = 1, both gnt = 0, both rvalid = 0, o_rdata = 0, o_dmem_wr_en = 0, o_dmem_addr/data/byte_sel = 0, o_core_stall = i_core_req.
  - Reset also clears: state = ST_CORE, starve counter = 0, rd_owner = none.
  - Reset asserted mid-burst or with a read in flight drops the pending rvalid and the lock.
- States:
  - ST_CORE: M0 priority. If i_core_req, grant M0. Else if i_ext_req, grant M1. If M1 is granted with i_ext_lock = 1, go to ST_EXT_LOCK.
  - ST_EXT_LOCK: M1 owns the port. Grant M1 whenever i_ext_req; M0 is stalled. Return to ST_CORE on the first cycle with i_ext_lock = 0, or on a granted M1 access with i_ext_lock = 0. That cycle is still M1's.
- Grant and dmem drive:
  - Grant is combinational from state and requests; at most one gnt per cycle.
  - The dmem port is driven combinationally from the granted master's wen/addr/wdata/bsel.
  - With no grant: o_dmem_wr_en = 0 and addr/data/bsel = 0.
- Read return:
  - A granted read (wen = 0) registers rd_owner.
  - Next cycle: o_rdata = i_dmem_data, and the owner's rvalid = 1 for exactly one cycle.
  - A granted write produces no rvalid.
  - Back-to-back reads from alternating masters return in grant order, one per cycle.
- Simultaneous events:
  - Both req in ST_CORE without starve override: M0 wins, M1 waits, o_ext_gnt = 0.
  - A write and a read return in the same cycle are independent; the port is pipelined.
- M0 requests that are not granted are never dropped: the stall holds the MEM stage, and the request stays asserted until gnt.

Optional Feature:
- DMEM_ARB_STARVE_EN defined:
  - 4-bit-min counter, width clog2(STARVE_MAX+1).
  - Increments each cycle M1 requests and M0 is granted in ST_CORE; clears when M1 is granted or i_ext_req = 0.
  - When counter == STARVE_MAX and both request, M1 wins that cycle and M0 stalls.
  - Counter saturates and never wraps.
- DMEM_ARB_STARVE_EN undefined: strict M0 priority in ST_CORE, no counter logic.

Test Plan:
- Reset: hold i_rst 3 cycles with both req = 1 -> gnt = 0, rvalid = 0, o_dmem_wr_en = 0, o_core_stall = 1. Release -> M0 granted first cycle.
- M0 read at addr 0x10; dmem returns 0xDEADBEEF -> o_core_gnt = 1 in cycle N, o_core_rvalid = 1 with o_rdata = 0xDEADBEEF in N+1, o_ext_rvalid = 0.
- Both request a write every cycle for 4 cycles (M0 addr 0x20, M1 addr 0x40) -> M0 granted all 4, M1 gnt = 0, dmem addr = 0x20 each cycle. With DMEM_ARB_STARVE_EN and STARVE_MAX = 2: cycle 3 grants M1 (addr 0x40), o_core_stall = 1 in that cycle only.
- M1 locked burst: i_ext_lock = 1, 3 reads at 0x100/0x104/0x108 while M0 requests -> o_ext_gnt 3 cycles, o_core_stall = 1 throughout. After lock drops, M0 is granted next cycle. o_ext_rvalid follows each grant by 1 cycle.
- Alternating reads M0@0x0, M1@0x4, M0@0x8 in consecutive cycles -> rvalids alternate core/ext/core, each with the matching data, one cycle after each grant.
- Reset asserted the cycle after a granted M1 read -> o_ext_rvalid stays 0, state returns to ST_CORE, lock cleared.
